axis_red_pitaya_dac_mc: RTL and testbench

Multi-channel AXI-Stream to DAC output stage for Red Pitaya-class boards. Buffers packed multi-channel samples in a small FIFO and replays them at a programmable sample rate. Converts each channel from signed two's complement to DAC format, with optional saturation. Handles underrun explicitly and reports status. Sits between the DSP/DMA stream and the DAC pins, all in the aclk domain.

---
 rtl/red_pitaya_dac_pkg.sv | 43 ++++
 rtl/axis_dac_sample_fifo.sv | 59 +++++
 rtl/axis_red_pitaya_dac_mc.sv | 170 +++++++++++++++++
 tb/tb_axis_red_pitaya_dac_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_dac_pkg.sv
// Shared types and sample-conversion helpers for the Red Pitaya DAC output stage.
// Optional build macro DAC_SATURATION_EN selects clamping instead of wrap-around truncation.
package red_pitaya_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_RUN      = 2'd2,
    ST_UNDERRUN = 2'd3
  } dac_state_t;

  function automatic logic [31:0] dac_mid(input int width, input logic offset_binary);
    logic [31:0] mid;
    if (offset_binary) mid = 32'd1 << (width - 1);
    else mid = 32'd0;
    return mid;
  endfunction

  // Reduces a sign-extended sample to a width-bit DAC code; caller keeps the low width bits.
  function automatic logic [31:0] dac_convert(input logic signed [31:0] sample, input int width,
                                              input logic offset_binary);
    logic signed [31:0] v;
    logic        [31:0] code;
`ifdef DAC_SATURATION_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
`endif
`ifdef DAC_SATURATION_EN
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (sample > hi) v = hi;
    else if (sample < lo) v = lo;
    else v = sample;
`else
    v = sample;
`endif
    code = $unsigned(v) & ((32'd1 << width) - 32'd1);
    if (offset_binary) code = code ^ (32'd1 << (width - 1));
    else code = code;
    return code;
  endfunction

endpackage

// File: rtl/axis_dac_sample_fifo.sv
// Synchronous sample FIFO with occupancy count and synchronous flush; head word is read combinationally.
module axis_dac_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_fill == FULL_LVL);
  assign o_empty = (r_fill == '0);
  assign o_fill  = r_fill;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW + 1)'(1);
        2'b01:   r_fill <= r_fill - (AW + 1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end
endmodule

// File: rtl/axis_red_pitaya_dac_mc.sv
// Multi-channel AXI-Stream to DAC stage: prefilled FIFO replayed at a programmable rate with underrun handling.
// Define DAC_SATURATION_EN to clamp out-of-range samples instead of wrapping them.
module axis_red_pitaya_dac_mc
  import red_pitaya_dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int CHANNEL_WIDTH    = 16,
  parameter int NUM_CHANNELS     = 2,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 16,
  parameter int PREFILL          = 8,
  parameter int RATE_WIDTH       = 16,
  parameter int OFFSET_BINARY    = 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   cfg_enable,
  input  logic [RATE_WIDTH-1:0]                  cfg_rate,
  input  logic                                   cfg_hold,
  output logic                                   s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  output logic [NUM_CHANNELS*DAC_DATA_WIDTH-1:0] dac_dat,
  output logic                                   dac_wrt,
  output logic [1:0]                             sts_state,
  output logic [$clog2(FIFO_DEPTH):0]            sts_fill,
  output logic [15:0]                            sts_underrun_cnt
);
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FILL_W-1:0] PREFILL_LVL = FILL_W'(PREFILL);
  localparam logic [DAC_DATA_WIDTH-1:0] MID_CODE =
    DAC_DATA_WIDTH'(dac_mid(DAC_DATA_WIDTH, 1'(OFFSET_BINARY)));
  localparam logic [NUM_CHANNELS*DAC_DATA_WIDTH-1:0] MID_ALL = {NUM_CHANNELS{MID_CODE}};

  dac_state_t                            r_state;
  dac_state_t                            w_state_nxt;
  logic [RATE_WIDTH-1:0]                 r_cnt;
  logic [RATE_WIDTH-1:0]                 r_rate;
  logic [NUM_CHANNELS*DAC_DATA_WIDTH-1:0] r_dac_dat;
  logic [NUM_CHANNELS*DAC_DATA_WIDTH-1:0] w_conv;
  logic                                  r_dac_wrt;
  logic [15:0]                           r_underrun_cnt;
  logic [AXIS_TDATA_WIDTH-1:0]           w_head;
  logic [FILL_W-1:0]                     w_fill;
  logic                                  w_full;
  logic                                  w_empty;
  logic                                  w_active;
  logic                                  w_tick;
  logic                                  w_push;
  logic                                  w_pop;
  logic                                  w_disable;
  logic                                  w_underrun_enter;
  logic                                  w_underrun_out;

  assign w_active         = (r_state == ST_RUN) || (r_state == ST_UNDERRUN);
  assign w_tick           = w_active && (r_cnt == r_rate);
  assign w_disable        = !cfg_enable;
  assign s_axis_tready    = (r_state != ST_IDLE) && !w_full;
  assign w_push           = s_axis_tvalid && s_axis_tready;
  assign dac_dat          = r_dac_dat;
  assign dac_wrt          = r_dac_wrt;
  assign sts_state        = r_state;
  assign sts_fill         = w_fill;
  assign sts_underrun_cnt = r_underrun_cnt;

  axis_dac_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .i_flush (w_disable),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (s_axis_tdata),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (w_fill)
  );

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_conv
    assign w_conv[g*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = DAC_DATA_WIDTH'(dac_convert(
      32'($signed(w_head[g*CHANNEL_WIDTH +: CHANNEL_WIDTH])), DAC_DATA_WIDTH, 1'(OFFSET_BINARY)));
  end

  // Next-state and per-tick action decode
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_underrun_enter = 1'b0;
    w_underrun_out   = 1'b0;
    if (w_disable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_FILL;
        ST_FILL: begin
          if (w_fill >= PREFILL_LVL) w_state_nxt = ST_RUN;
          else w_state_nxt = ST_FILL;
        end
        ST_RUN: begin
          if (!w_tick) begin
            w_state_nxt = ST_RUN;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt      = ST_UNDERRUN;
            w_underrun_enter = 1'b1;
            w_underrun_out   = 1'b1;
          end
        end
        ST_UNDERRUN: begin
          if (!w_tick) begin
            w_state_nxt = ST_UNDERRUN;
          end else if (w_fill >= PREFILL_LVL) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_underrun_out = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end

  // Rate counter; the period is re-sampled only at a wrap or while not replaying
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt  <= '0;
      r_rate <= '0;
    end else begin
      if (w_active && cfg_enable) r_cnt <= w_tick ? '0 : r_cnt + RATE_WIDTH'(1);
      else r_cnt <= '0;
      if (!w_active || w_tick) r_rate <= cfg_rate;
    end
  end

  // DAC code and write strobe
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_dac_dat <= MID_ALL;
      r_dac_wrt <= 1'b0;
    end else if (w_disable && (r_state != ST_IDLE)) begin
      r_dac_dat <= MID_ALL;
      r_dac_wrt <= 1'b1;
    end else if (w_pop) begin
      r_dac_dat <= w_conv;
      r_dac_wrt <= 1'b1;
    end else if (w_underrun_out) begin
      if (!cfg_hold) r_dac_dat <= MID_ALL;
      r_dac_wrt <= 1'b1;
    end else begin
      r_dac_wrt <= 1'b0;
    end
  end

  // Saturating underrun event counter, kept across disable
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_underrun_cnt <= 16'd0;
    else if (w_underrun_enter && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end
endmodule

// File: tb/tb_axis_red_pitaya_dac_mc.sv
// Directed self-checking bench for axis_red_pitaya_dac_mc with default parameters.
module tb_axis_red_pitaya_dac_mc;
  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_rate = 16'd0;
  logic        cfg_hold = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic [27:0] dac_dat;
  logic        dac_wrt;
  logic [1:0]  sts_state;
  logic [4:0]  sts_fill;
  logic [15:0] sts_underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [27:0] MID2  = {14'h2000, 14'h2000};
  localparam logic [27:0] EXP_A = {14'h1FFF, 14'h2000};
`ifdef DAC_SATURATION_EN
  localparam logic [27:0] EXP_B = {14'h0000, 14'h3FFF};
`else
  localparam logic [27:0] EXP_B = {14'h2000, 14'h1FFF};
`endif
  localparam logic [31:0] BEAT_A = {16'hFFFF, 16'h0000};
  localparam logic [31:0] BEAT_B = {16'h8000, 16'h7FFF};

  axis_red_pitaya_dac_mc dut (
    .aclk             (aclk),
    .areset           (areset),
    .cfg_enable       (cfg_enable),
    .cfg_rate         (cfg_rate),
    .cfg_hold         (cfg_hold),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .dac_dat          (dac_dat),
    .dac_wrt          (dac_wrt),
    .sts_state        (sts_state),
    .sts_fill         (sts_fill),
    .sts_underrun_cnt (sts_underrun_cnt)
  );

  always #5 aclk = ~aclk;

  // ch0 = 0x0100*(k+1), ch1 = -1-k
  function automatic logic [31:0] beat_c(input int k);
    return {16'(16'hFFFF - k), 16'(16'h0100 * (k + 1))};
  endfunction

  function automatic logic [27:0] exp_c(input int k);
    return {14'(14'h1FFF - k), 14'(14'h2100 + 14'h0100 * k)};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset values
    #2 areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    check("rst dac_dat", 32'(dac_dat), 32'(MID2));
    check("rst dac_wrt", 32'(dac_wrt), 32'd0);
    check("rst tready", 32'(s_axis_tready), 32'd0);
    check("rst state", 32'(sts_state), 32'd0);
    check("rst fill", 32'(sts_fill), 32'd0);
    check("rst ucnt", 32'(sts_underrun_cnt), 32'd0);
    step();
    check("idle stays", 32'(sts_state), 32'd0);

    // Rate 0: back-to-back replay of two conversion patterns
    cfg_rate = 16'd0;
    cfg_enable = 1'b1;
    step();
    check("t2 fill state", 32'(sts_state), 32'd1);
    check("t2 tready", 32'(s_axis_tready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      s_axis_tdata = (k < 4) ? BEAT_A : BEAT_B;
      s_axis_tvalid = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    check("t2 prefill", 32'(sts_fill), 32'd8);
    check("t2 still fill", 32'(sts_state), 32'd1);
    step();
    check("t2 run", 32'(sts_state), 32'd2);
    check("t2 no wrt yet", 32'(dac_wrt), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2 wrt", 32'(dac_wrt), 32'd1);
      check("t2 dac", 32'(dac_dat), 32'((k < 4) ? EXP_A : EXP_B));
      check("t2 fill", 32'(sts_fill), 32'(7 - k));
    end
    step();
    check("t2 underrun state", 32'(sts_state), 32'd3);
    check("t2 underrun wrt", 32'(dac_wrt), 32'd1);
    check("t2 underrun mid", 32'(dac_dat), 32'(MID2));
    check("t2 ucnt", 32'(sts_underrun_cnt), 32'd1);
    step();
    check("t2 underrun repeat wrt", 32'(dac_wrt), 32'd1);
    check("t2 ucnt kept", 32'(sts_underrun_cnt), 32'd1);

    // Asynchronous reset mid-operation
    areset = 1'b1;
    #2;
    check("arst state", 32'(sts_state), 32'd0);
    check("arst dac", 32'(dac_dat), 32'(MID2));
    check("arst wrt", 32'(dac_wrt), 32'd0);
    check("arst fill", 32'(sts_fill), 32'd0);
    check("arst ucnt", 32'(sts_underrun_cnt), 32'd0);
    check("arst tready", 32'(s_axis_tready), 32'd0);
    cfg_enable = 1'b0;
    @(posedge aclk);
    #1 areset = 1'b0;

    // Rate 3 with hold, then midscale, then recovery
    cfg_rate = 16'd3;
    cfg_hold = 1'b1;
    cfg_enable = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      s_axis_tdata = beat_c(k);
      s_axis_tvalid = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    check("t4 run", 32'(sts_state), 32'd2);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("t4 gap", 32'(dac_wrt), 32'd0);
      end
      step();
      check("t4 wrt", 32'(dac_wrt), 32'd1);
      check("t4 dac", 32'(dac_dat), 32'(exp_c(k)));
    end
    for (int j = 0; j < 3; j++) begin
      step();
      check("t4 ur gap", 32'(dac_wrt), 32'd0);
    end
    step();
    check("t4 ur wrt", 32'(dac_wrt), 32'd1);
    check("t4 ur state", 32'(sts_state), 32'd3);
    check("t4 hold dac", 32'(dac_dat), 32'(exp_c(7)));
    check("t4 ucnt", 32'(sts_underrun_cnt), 32'd1);
    cfg_hold = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t4 mid gap", 32'(dac_wrt), 32'd0);
    end
    step();
    check("t4 mid wrt", 32'(dac_wrt), 32'd1);
    check("t4 mid dac", 32'(dac_dat), 32'(MID2));
    check("t4 mid state", 32'(sts_state), 32'd3);
    for (int k = 0; k < 8; k++) begin
      s_axis_tdata = beat_c(k);
      s_axis_tvalid = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    check("t4 refill", 32'(sts_fill), 32'd8);
    n = 0;
    do begin
      step();
      n++;
    end while (!dac_wrt && n < 8);
    check("t4 resume wrt", 32'(dac_wrt), 32'd1);
    check("t4 resume state", 32'(sts_state), 32'd2);
    check("t4 resume dac", 32'(dac_dat), 32'(exp_c(0)));
    check("t4 resume fill", 32'(sts_fill), 32'd7);
    check("t4 ucnt after resume", 32'(sts_underrun_cnt), 32'd1);

    // Rate 15 with continuous input: FIFO fills and backpressures
    cfg_rate = 16'd15;
    s_axis_tdata = 32'h1234_5678;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (sts_fill != 5'd16 && n < 60) begin
      step();
      n++;
    end
    check("t5 full", 32'(sts_fill), 32'd16);
    check("t5 tready low", 32'(s_axis_tready), 32'd0);
    n = 0;
    step();
    while (!dac_wrt && n < 40) begin
      check("t5 full tready", 32'(s_axis_tready), 32'd0);
      step();
      n++;
    end
    check("t5 pop wrt", 32'(dac_wrt), 32'd1);
    check("t5 pop fill", 32'(sts_fill), 32'd15);
    check("t5 pop tready", 32'(s_axis_tready), 32'd1);
    step();
    check("t5 refull", 32'(sts_fill), 32'd16);
    check("t5 refull tready", 32'(s_axis_tready), 32'd0);

    // Disable mid-RUN with five entries queued
    s_axis_tvalid = 1'b0;
    n = 0;
    while (sts_fill != 5'd5 && n < 400) begin
      step();
      n++;
    end
    check("t6 fill5", 32'(sts_fill), 32'd5);
    check("t6 run", 32'(sts_state), 32'd2);
    cfg_enable = 1'b0;
    step();
    check("t6 idle", 32'(sts_state), 32'd0);
    check("t6 flushed", 32'(sts_fill), 32'd0);
    check("t6 mid", 32'(dac_dat), 32'(MID2));
    check("t6 wrt pulse", 32'(dac_wrt), 32'd1);
    check("t6 tready", 32'(s_axis_tready), 32'd0);
    check("t6 ucnt kept", 32'(sts_underrun_cnt), 32'd1);
    step();
    check("t6 wrt once", 32'(dac_wrt), 32'd0);
    check("t6 still idle", 32'(sts_state), 32'd0);
    check("t6 mid held", 32'(dac_dat), 32'(MID2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
